// File: rtl/universal_reg_pkg.sv
// Shared definitions for the universal register: operating mode encodings.
package universal_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INC  = 3'd6;
    localparam logic [2:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/universal_reg_delay_line.sv
// DELAY-stage free-running delay of the register value, with a valid flag
// that rises once every stage holds data captured after reset release.
module universal_reg_delay_line #(
    parameter int               WIDTH       = 8,
    parameter int               DELAY       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int CW = $clog2(DELAY + 1);

    logic [WIDTH-1:0] stage [DELAY];
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) stage[i] <= RESET_VALUE;
            cnt <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
            // Saturate so the flag stays high until the next reset
            if (cnt != CW'(DELAY)) cnt <= cnt + CW'(1);
        end
    end

    assign dout  = stage[DELAY-1];
    assign valid = (cnt == CW'(DELAY));

endmodule

// File: rtl/universal_reg.sv
// WIDTH-bit general-purpose register: hold/load/shift/rotate/count modes,
// synchronous clear, wrap pulse, shifted-out bit and a delayed copy of q.
module universal_reg
    import universal_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               DELAY       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sclr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             wrap,
    output logic             zero,
    output logic [WIDTH-1:0] q_dly,
    output logic             dly_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= RESET_VALUE;
            sout <= 1'b0;
            wrap <= 1'b0;
        end else if (sclr) begin
            q    <= RESET_VALUE;
            sout <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_LOAD: q <= d;
                    MODE_SHL: begin
                        q    <= {q[WIDTH-2:0], sin};
                        sout <= q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        q    <= {sin, q[WIDTH-1:1]};
                        sout <= q[0];
                    end
                    MODE_ROL: begin
                        q    <= {q[WIDTH-2:0], q[WIDTH-1]};
                        sout <= q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        q    <= {q[0], q[WIDTH-1:1]};
                        sout <= q[0];
                    end
                    MODE_INC: begin
                        q    <= q + WIDTH'(1);
                        wrap <= (q == '1);
                    end
                    MODE_DEC: begin
                        q    <= q - WIDTH'(1);
                        wrap <= (q == '0);
                    end
                    default: q <= q;
                endcase
            end
        end
    end

    assign zero = (q == '0);

    universal_reg_delay_line #(
        .WIDTH      (WIDTH),
        .DELAY      (DELAY),
        .RESET_VALUE(RESET_VALUE)
    ) u_delay_line (
        .clk  (clk),
        .reset(reset),
        .din  (q),
        .dout (q_dly),
        .valid(dly_valid)
    );

endmodule

// File: tb/tb_universal_reg.sv
// Self-checking bench for universal_reg: directed vector table, hand-written
// reset/delay sequences, and randomized traffic against an arithmetic model.
module tb_universal_reg;

    localparam int         W  = 8;
    localparam int         DL = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       sclr = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic       wrap;
    logic       zero;
    logic [7:0] q_dly;
    logic       dly_valid;

    int checks = 0;
    int errors = 0;

    universal_reg #(.WIDTH(W), .RESET_VALUE(RV), .DELAY(DL)) dut (
        .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .d(d),
        .sin(sin), .q(q), .sout(sout), .wrap(wrap), .zero(zero),
        .q_dly(q_dly), .dly_valid(dly_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers and a history queue of post-edge q values
    int m_q, m_sout, m_wrap, m_edges;
    int qh[$];

    task automatic model_reset();
        m_q = RV; m_sout = 0; m_wrap = 0; m_edges = 0;
        qh.delete();
    endtask

    task automatic model_edge(input int e, input int s, input int m, input int dd, input int si);
        if (m_edges < DL) m_edges++;
        if (s != 0) begin
            m_q = RV; m_sout = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (e != 0) begin
                case (m)
                    1: m_q = dd;
                    2: begin m_sout = m_q / 128;  m_q = (m_q * 2) % 256 + si; end
                    3: begin m_sout = m_q % 2;    m_q = m_q / 2 + si * 128; end
                    4: begin m_sout = m_q / 128;  m_q = (m_q * 2) % 256 + m_q / 128; end
                    5: begin m_sout = m_q % 2;    m_q = m_q / 2 + (m_q % 2) * 128; end
                    6: begin m_wrap = (m_q == 255); m_q = (m_q + 1) % 256; end
                    7: begin m_wrap = (m_q == 0);   m_q = (m_q + 255) % 256; end
                    default: ;
                endcase
            end
        end
        qh.push_back(m_q);
        if (qh.size() > DL + 1) void'(qh.pop_front());
    endtask

    function automatic int model_qdly();
        return (qh.size() > DL) ? qh[qh.size() - 1 - DL] : int'(RV);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("q", int'(q), m_q);
        chk("sout", int'(sout), m_sout);
        chk("wrap", int'(wrap), m_wrap);
        chk("zero", int'(zero), int'(m_q == 0));
        chk("q_dly", int'(q_dly), model_qdly());
        chk("dly_valid", int'(dly_valid), int'(m_edges >= DL));
    endtask

    // Drive inputs, take one edge, sample 1 time unit later
    task automatic step(input logic e, input logic s, input logic [2:0] m,
                        input logic [7:0] dd, input logic si);
        en = e; sclr = s; mode = m; d = dd; sin = si;
        @(posedge clk);
        model_edge(int'(e), int'(s), int'(m), int'(dd), int'(si));
        #1;
        check_model();
    endtask

    typedef struct {
        logic       en;
        logic       sclr;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_sout;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // en sclr mode d sin | q sout wrap
        vecs.push_back('{1, 0, 3'd1, 8'h81, 0, 8'h81, 0, 0});
        vecs.push_back('{1, 0, 3'd2, 8'h00, 0, 8'h02, 1, 0});
        vecs.push_back('{1, 0, 3'd5, 8'h00, 0, 8'h01, 0, 0});
        vecs.push_back('{1, 0, 3'd3, 8'h00, 1, 8'h80, 1, 0});
        vecs.push_back('{1, 0, 3'd4, 8'h00, 0, 8'h01, 1, 0});
        vecs.push_back('{1, 0, 3'd1, 8'hFE, 0, 8'hFE, 1, 0});
        vecs.push_back('{1, 0, 3'd6, 8'h00, 0, 8'hFF, 1, 0});
        vecs.push_back('{1, 0, 3'd6, 8'h00, 0, 8'h00, 1, 1});
        vecs.push_back('{1, 0, 3'd7, 8'h00, 0, 8'hFF, 1, 1});
        vecs.push_back('{0, 0, 3'd6, 8'h00, 0, 8'hFF, 1, 0});
        vecs.push_back('{0, 0, 3'd6, 8'h00, 1, 8'hFF, 1, 0});
        vecs.push_back('{0, 0, 3'd6, 8'h00, 0, 8'hFF, 1, 0});
        vecs.push_back('{1, 1, 3'd1, 8'h33, 0, 8'hA5, 0, 0});
        vecs.push_back('{1, 0, 3'd7, 8'h00, 0, 8'hA4, 0, 0});
        vecs.push_back('{1, 0, 3'd1, 8'h11, 0, 8'h11, 0, 0});
        vecs.push_back('{1, 0, 3'd1, 8'h22, 0, 8'h22, 0, 0});
        vecs.push_back('{1, 0, 3'd1, 8'h33, 0, 8'h33, 0, 0});

        // Async reset with no edge required
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_q", int'(q), int'(RV));
        chk("rst_q_dly", int'(q_dly), int'(RV));
        chk("rst_dly_valid", int'(dly_valid), 0);
        chk("rst_sout", int'(sout), 0);
        chk("rst_wrap", int'(wrap), 0);
        @(posedge clk); #1;
        chk("rst_hold_q", int'(q), int'(RV));
        chk("rst_hold_dly_valid", int'(dly_valid), 0);
        reset = 1'b0;

        step(0, 0, 3'd0, 8'h00, 0);
        chk("dly_valid_1edge", int'(dly_valid), 0);
        step(0, 0, 3'd0, 8'h00, 0);
        chk("dly_valid_2edges", int'(dly_valid), 1);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].sclr, vecs[i].mode, vecs[i].d, vecs[i].sin);
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_sout", i), int'(sout), int'(vecs[i].exp_sout));
            chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].exp_q == 8'h00));
        end
        // Loads of 11, 22, 33 emerge on q_dly two edges later
        chk("qdly_11", int'(q_dly), 32'h11);
        step(0, 0, 3'd0, 8'h00, 0);
        chk("qdly_22", int'(q_dly), 32'h22);
        step(0, 0, 3'd0, 8'h00, 0);
        chk("qdly_33", int'(q_dly), 32'h33);

        // Reset asserted between edges right after a wrapping increment
        step(1, 0, 3'd1, 8'hFF, 0);
        step(1, 0, 3'd6, 8'h00, 0);
        chk("pre_rst_wrap", int'(wrap), 1);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_q", int'(q), int'(RV));
        chk("mid_rst_wrap", int'(wrap), 0);
        chk("mid_rst_dly_valid", int'(dly_valid), 0);
        chk("mid_rst_q_dly", int'(q_dly), int'(RV));
        #2 reset = 1'b0;
        step(1, 0, 3'd6, 8'h00, 0);
        chk("post_rst_inc", int'(q), int'(RV) + 1);

        // Randomized traffic with occasional async resets between edges
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 96) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_model();
                #1 reset = 1'b0;
            end
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
